// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity constants and frame-length helper for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Serial bits in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit word FIFO with occupancy count
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - buffered UART transmitter: FIFO, frame FSM, bit timer and shift register
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_core: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_core: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_core: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (frame_bits(DATA_BITS, PARITY, STOP_BITS) > 13) begin : g_bad_frame
    $error("uart_tx_core: frame longer than 13 bits");
  end

  tx_state_t            state;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 start_frame;

  // A new frame starts from IDLE, or straight out of the last stop cycle, whenever a word waits.
  assign start_frame = !fifo_empty &&
                       ((state == ST_IDLE) || (state == ST_STOP && bit_cnt == STOP_LAST));

  assign tx_ready = !fifo_full;
  assign busy     = (state != ST_IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (tx_data),
    .push  (tx_valid),
    .pop   (start_frame),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame sequencer: each state times its bit(s) and registers the next line level on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      bit_cnt <= bit_cnt + CNT_ONE;
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (start_frame) begin
            shift_q  <= fifo_rdata;
            parity_q <= (^fifo_rdata) ^ PAR_INV;
            state    <= ST_START;
            uart_tx  <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
            uart_tx <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              if (HAS_PAR) begin
                state   <= ST_PARITY;
                uart_tx <= parity_q;
              end else begin
                state   <= ST_STOP;
                uart_tx <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
              shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
              uart_tx <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            state   <= ST_STOP;
            uart_tx <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_cnt == STOP_LAST) begin
            bit_cnt <= '0;
            if (start_frame) begin
              shift_q  <= fifo_rdata;
              parity_q <= (^fifo_rdata) ^ PAR_INV;
              state    <= ST_START;
              uart_tx  <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - self-checking bench for uart_tx_core across four parameter sets
module tb_uart_tx_core;

  localparam int NI = 4;
  localparam int NC = 8192;

  function automatic int db_of(input int i);
    return (i == 3) ? 5 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction
  function automatic int stop_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int cpb_of(input int i);
    return (i == 3) ? 3 : 4;
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] tx_data    [NI];
  logic       tx_valid   [NI];
  logic       tx_ready   [NI];
  logic       uart_tx    [NI];
  logic       busy       [NI];
  logic [2:0] fifo_count [NI];

  always #5 clk = ~clk;

  uart_tx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .uart_tx(uart_tx[0]), .busy(busy[0]), .fifo_count(fifo_count[0]));
  uart_tx_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1][7:0]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .uart_tx(uart_tx[1]), .busy(busy[1]), .fifo_count(fifo_count[1]));
  uart_tx_core #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2][7:0]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .uart_tx(uart_tx[2]), .busy(busy[2]), .fifo_count(fifo_count[2]));
  uart_tx_core #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(3), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .tx_data(tx_data[3][4:0]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
    .uart_tx(uart_tx[3]), .busy(busy[3]), .fifo_count(fifo_count[3]));

  // Reference model: per-cycle expected line level, frame occupancy and FIFO push/pop edges.
  byte  exp_line [NI][NC];
  byte  in_frame [NI][NC];
  byte  acc_at   [NI][NC];
  byte  pop_at   [NI][NC];
  byte  trace    [NI][NC];
  int   occ        [NI];
  int   t_free     [NI];
  int   last_start [NI];
  int   prev_start [NI];
  logic       stim_valid [NI];
  logic [8:0] stim_data  [NI];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear_from(input int from);
    for (int i = 0; i < NI; i++) begin
      for (int c = from; c < NC; c++) begin
        exp_line[i][c] = 8'd1;
        in_frame[i][c] = 8'd0;
        acc_at[i][c]   = 8'd0;
        pop_at[i][c]   = 8'd0;
      end
      occ[i]    = 0;
      t_free[i] = 0;
    end
  endtask

  // Word accepted at edge a: it starts at a+1 or as soon as the line frees, frames packed back to back.
  task automatic add_frame(input int i, input logic [8:0] w, input int a);
    int start;
    int pos;
    logic p;
    bit bits[$];
    start = (a + 1 > t_free[i]) ? a + 1 : t_free[i];
    pop_at[i][start] += 8'd1;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int j = 0; j < db_of(i); j++) begin
      bits.push_back(w[j]);
      p ^= w[j];
    end
    if (par_of(i) == 2) bits.push_back(p);
    else if (par_of(i) == 1) bits.push_back(~p);
    for (int s = 0; s < stop_of(i); s++) bits.push_back(1'b1);
    pos = start;
    foreach (bits[k]) begin
      for (int c = 0; c < cpb_of(i); c++) begin
        exp_line[i][pos] = {7'd0, bits[k]};
        in_frame[i][pos] = 8'd1;
        pos++;
      end
    end
    prev_start[i] = last_start[i];
    last_start[i] = start;
    t_free[i]     = pos;
  endtask

  task automatic step();
    @(negedge clk);
    if (cyc >= NC - 600) begin
      $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, NC - 600);
      $fatal(1, "cycle budget exhausted");
    end
    for (int i = 0; i < NI; i++) begin
      occ[i] += int'(acc_at[i][cyc]) - int'(pop_at[i][cyc]);
      trace[i][cyc] = {7'd0, uart_tx[i]};
      check($sformatf("uart_tx[%0d]@%0d", i, cyc), int'(uart_tx[i]), int'(exp_line[i][cyc]));
      check($sformatf("fifo_count[%0d]@%0d", i, cyc), int'(fifo_count[i]), occ[i]);
      check($sformatf("tx_ready[%0d]@%0d", i, cyc), int'(tx_ready[i]), (occ[i] < 4) ? 1 : 0);
      check($sformatf("busy[%0d]@%0d", i, cyc), int'(busy[i]),
            ((in_frame[i][cyc] != 0) || occ[i] > 0) ? 1 : 0);
    end
    for (int i = 0; i < NI; i++) begin
      tx_valid[i] = stim_valid[i];
      tx_data[i]  = stim_data[i];
      if (stim_valid[i] && !rst && occ[i] < 4) begin
        acc_at[i][cyc + 1] += 8'd1;
        add_frame(i, stim_data[i], cyc + 1);
      end
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NI; i++) begin
      stim_valid[i] = 1'b0;
      stim_data[i]  = 9'h0;
    end
  endtask

  task automatic push_all(input logic [8:0] d);
    for (int i = 0; i < NI; i++) begin
      stim_valid[i] = 1'b1;
      stim_data[i]  = d;
    end
  endtask

  task automatic drain();
    int  budget;
    bit  done;
    clear_stim();
    budget = 2000;
    done = 1'b0;
    while (!done && budget > 0) begin
      step();
      budget--;
      done = 1'b1;
      for (int i = 0; i < NI; i++) if (occ[i] != 0 || t_free[i] > cyc) done = 1'b0;
    end
    if (!done) check("drain_timeout", 1, 0);
    step();
    step();
  endtask

  int a0;
  int s1;
  int s2;
  int ones;
  logic [9:0] v_first;
  logic [9:0] v_last;

  initial begin
    model_clear_from(0);
    for (int i = 0; i < NI; i++) begin
      last_start[i] = 0;
      prev_start[i] = 0;
      tx_valid[i]   = 1'b0;
      tx_data[i]    = 9'h0;
    end
    clear_stim();

    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_uart_tx[%0d]", i), int'(uart_tx[i]), 1);
      check($sformatf("reset_busy[%0d]", i), int'(busy[i]), 0);
      check($sformatf("reset_count[%0d]", i), int'(fifo_count[i]), 0);
      check($sformatf("reset_ready[%0d]", i), int'(tx_ready[i]), 1);
    end
    rst = 1'b0;
    repeat (3) step();

    // Single word: exact frame shapes and parity bits.
    push_all(9'h041);
    stim_data[3] = 9'h1FF;
    step();
    a0 = cyc + 1;
    drain();
    check("start_not_before_accept", int'(trace[0][a0]), 1);
    check("start_one_after_accept", int'(trace[0][a0 + 1]), 0);
    for (int j = 0; j < 10; j++) begin
      v_first[j] = trace[0][a0 + 1 + j * 4][0];
      v_last[j]  = trace[0][a0 + 1 + j * 4 + 3][0];
    end
    check("frame_41_first", int'(v_first), int'(10'b1010000010));
    check("frame_41_last", int'(v_last), int'(10'b1010000010));
    check("even_parity_41", int'(trace[1][a0 + 1 + 36 + 2]), 0);
    check("odd_parity_41", int'(trace[2][a0 + 1 + 36 + 2]), 1);
    v_first = '0;
    v_last  = '0;
    for (int j = 0; j < 7; j++) begin
      v_first[j] = trace[3][a0 + 1 + j * 3][0];
      v_last[j]  = trace[3][a0 + 1 + j * 3 + 2][0];
    end
    check("frame_5bit_first", int'(v_first), int'(10'b0001111110));
    check("frame_5bit_last", int'(v_last), int'(10'b0001111110));

    // Back-to-back words: two stop bits then an immediate start bit.
    push_all(9'h0A5);
    step();
    a0 = cyc + 1;
    push_all(9'h03C);
    step();
    drain();
    s1 = a0 + 1;
    s2 = s1 + 48;
    ones = 0;
    for (int c = s2 - 8; c < s2; c++) ones += int'(trace[1][c]);
    check("stop2_ones", ones, 8);
    check("stop2_parity_a5", int'(trace[1][s2 - 9]), 0);
    check("b2b_next_start", int'(trace[1][s2]), 0);
    check("b2b_next_start_8n1", int'(trace[0][s1 + 40]), 0);

    push_all(9'h007);
    step();
    a0 = cyc + 1;
    drain();
    check("even_parity_07", int'(trace[1][a0 + 1 + 37]), 1);
    check("odd_parity_07", int'(trace[2][a0 + 1 + 37]), 0);

    // Overflow: six consecutive words while idle, the sixth is refused.
    for (int k = 0; k < 6; k++) begin
      push_all(9'h010 + 9'(k));
      step();
    end
    clear_stim();
    step();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("overflow_count[%0d]", i), int'(fifo_count[i]), 4);
      check($sformatf("overflow_ready[%0d]", i), int'(tx_ready[i]), 0);
    end
    drain();

    // Reset in the middle of data bit 3.
    push_all(9'h041);
    step();
    a0 = cyc + 1;
    clear_stim();
    while (cyc < a0 + 1 + 17) step();
    check("bit3_low_before_reset", int'(uart_tx[0]), 0);
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("async_reset_uart_tx[%0d]", i), int'(uart_tx[i]), 1);
      check($sformatf("async_reset_count[%0d]", i), int'(fifo_count[i]), 0);
      check($sformatf("async_reset_ready[%0d]", i), int'(tx_ready[i]), 1);
      check($sformatf("async_reset_busy[%0d]", i), int'(busy[i]), 0);
    end
    model_clear_from(cyc + 1);
    step();
    step();
    rst = 1'b0;
    a0 = cyc + 1;
    repeat (100) step();
    ones = 0;
    for (int c = a0; c < a0 + 100; c++) ones += int'(trace[0][c]);
    check("idle_after_reset", ones, 100);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NI; i++) begin
        stim_valid[i] = ($urandom_range(0, 99) < 35);
        stim_data[i]  = 9'($urandom);
      end
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
